arbiter_rr: RTL
===============

ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter NUM_WRITERS, default 2, number of writer channels; SHALL be >= 2.
REQ-002 Parameter DATA_WIDTH, default 8, width of each writer's data word.
REQ-003 Parameter ROUND_ROBIN, default 1: 1 = rotating priority, 0 = fixed priority, highest index wins.
REQ-004 i_clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_req  input  NUM_WRITERS  per-writer write request; the writer holds its data while requesting.
REQ-007 i_data  input  NUM_WRITERS*DATA_WIDTH  flattened writer data; writer k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 i_fifo_full  input  1  downstream FIFO full; no grant while high.
REQ-009 o_busy  output  NUM_WRITERS  active-low grant; bit k low = writer k's data accepted this cycle.
REQ-010 o_we  output  1  FIFO write strobe.
REQ-011 o_data  output  DATA_WIDTH  FIFO write data, valid when o_we=1.
REQ-012 o_grant_id  output  max(1,$clog2(NUM_WRITERS))  index of the writer granted; valid when o_we=1.

Function
REQ-013 Eligible set at a rising edge = i_req & ~(granted-this-cycle mask); eligible SHALL be empty when i_fifo_full=1.
REQ-014 If the eligible set is non-empty at an edge, the winner k SHALL be registered: o_busy[k]=0, all other o_busy bits=1, o_we=1, o_data=i_data[k], o_grant_id=k, all valid the next cycle (1-cycle latency).
REQ-015 If the eligible set is empty, o_busy SHALL be all ones and o_we=0 in the next cycle; o_data and o_grant_id SHALL hold their last values.
REQ-016 Each grant SHALL last exactly one cycle; at most one o_busy bit SHALL be low in any cycle.
REQ-017 Back-to-back grants to different writers SHALL be allowed with no idle cycle; the writer granted in cycle N SHALL NOT be granted in cycle N+1 (its i_req is still high while it sees the grant).
REQ-018 ROUND_ROBIN=1: search SHALL start at pointer p and ascend with wrap-around at NUM_WRITERS-1 -> 0; on a grant to k, p SHALL become (k+1) mod NUM_WRITERS.
REQ-019 ROUND_ROBIN=1: a continuously requesting writer SHALL be granted within NUM_WRITERS grant cycles (no starvation).
REQ-020 ROUND_ROBIN=0: winner SHALL be the highest eligible index; p is unused.
REQ-021 i_fifo_full rising SHALL not cancel a grant already registered; it SHALL block only grants decided at edges where it is sampled high.
REQ-022 Writers that drop i_req before being granted SHALL simply leave the eligible set; no error state.

Reset
REQ-023 While i_reset_n=0: o_busy all ones, o_we=0, o_data=0, o_grant_id=0, p=0, granted mask=0.
REQ-024 Reset assertion mid-grant SHALL immediately (asynchronously) force o_we=0 and o_busy all ones; the interrupted word is dropped.
REQ-025 The first grant SHALL occur no earlier than the second rising edge after i_reset_n deasserts.

Structure
REQ-026 Parameter defaults and the helper clog2-width constant SHALL live in shared package arbiter_pkg.
REQ-027 Winner selection SHALL be a combinational sub-module arbiter_rr_pick (inputs: eligible vector, pointer, mode; outputs: valid, index); all registers stay in arbiter_rr.
REQ-028 The data mux SHALL be indexed by the registered winner index, with no latches.

Verification
REQ-029 Reset, then i_req=2'b01, i_data={8'hBB,8'hAA} -> next cycle o_busy=2'b10, o_we=1, o_data=8'hAA, o_grant_id=0.
REQ-030 NUM_WRITERS=4, ROUND_ROBIN=1, i_req=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one per cycle, o_we high every cycle.
REQ-031 ROUND_ROBIN=0, i_req=4'b1111 held -> grants alternate 3,2,3,2 (3 masked on the cycle after its grant).
REQ-032 i_fifo_full=1 with i_req=2'b11 for 5 cycles -> o_we=0, o_busy=2'b11 throughout; full drops -> grant to writer 0 one cycle later.
REQ-033 i_reset_n pulled low during a cycle with o_we=1 -> o_we=0 and o_busy all ones before the next edge; after release, p=0.
REQ-034 Formal properties on the bench: at most one o_busy bit low; o_we equals ~&o_busy; no grant to the same writer in consecutive cycles; starvation bound of REQ-019.

Source files
------------

// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared defaults and width helper for the round-robin write arbiter
//
// Purpose: parameter defaults for arbiter_rr and its interface, plus the
// grant-index width helper, max(1, clog2(n)).
// Ports: none (package).
package arbiter_pkg;

  localparam int NUM_WRITERS_DEF = 2;
  localparam int DATA_WIDTH_DEF  = 8;
  localparam bit ROUND_ROBIN_DEF = 1'b1;

  // A 1-writer index would otherwise collapse to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbiter_rr_if.sv
// rtl/arbiter_rr_if.sv - writer/FIFO-side bundle of the write arbiter
//
// Purpose: groups the writer request/data inputs and the FIFO write outputs.
// Signals:
//   i_req        writer requests, one bit per writer
//   i_data       flattened writer data, writer k at [k*DATA_WIDTH +: DATA_WIDTH]
//   i_fifo_full  downstream FIFO full
//   o_busy       active-low one-cycle grant per writer
//   o_we         FIFO write strobe
//   o_data       FIFO write data
//   o_grant_id   index of the granted writer
// Modports: master drives the requests (writers/FIFO side), slave is the arbiter.
interface arbiter_rr_if
  import arbiter_pkg::*;
#(
  parameter int NUM_WRITERS = NUM_WRITERS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF
);

  localparam int IDW = id_width(NUM_WRITERS);

  logic [NUM_WRITERS-1:0]            i_req;
  logic [NUM_WRITERS*DATA_WIDTH-1:0] i_data;
  logic                              i_fifo_full;
  logic [NUM_WRITERS-1:0]            o_busy;
  logic                              o_we;
  logic [DATA_WIDTH-1:0]             o_data;
  logic [IDW-1:0]                    o_grant_id;

  modport master (
    output i_req, i_data, i_fifo_full,
    input  o_busy, o_we, o_data, o_grant_id
  );

  modport slave (
    input  i_req, i_data, i_fifo_full,
    output o_busy, o_we, o_data, o_grant_id
  );

endinterface

// File: rtl/arbiter_rr_pick.sv
// rtl/arbiter_rr_pick.sv - combinational winner selection for the write arbiter
//
// Purpose: picks one writer from the eligible vector.
// Ports:
//   eligible_i     eligible writers
//   ptr_i          rotating search start (round-robin mode only)
//   round_robin_i  1 = ascending search from ptr_i with wrap, 0 = highest index wins
//   valid_o        some writer is eligible
//   idx_o          winning writer index (0 when valid_o is low)
module arbiter_rr_pick
  import arbiter_pkg::*;
#(
  parameter int NUM_WRITERS = NUM_WRITERS_DEF
) (
  input  logic [NUM_WRITERS-1:0]           eligible_i,
  input  logic [id_width(NUM_WRITERS)-1:0] ptr_i,
  input  logic                             round_robin_i,
  output logic                             valid_o,
  output logic [id_width(NUM_WRITERS)-1:0] idx_o
);

  localparam int IDW = id_width(NUM_WRITERS);

  always_comb begin
    int j;
    j       = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    if (round_robin_i) begin
      // Walk offsets from farthest to nearest so the last hit, i.e. the
      // eligible writer closest to the pointer, is the one kept.
      for (int s = NUM_WRITERS - 1; s >= 0; s--) begin
        j = int'(ptr_i) + s;
        if (j >= NUM_WRITERS) begin
          j = j - NUM_WRITERS;
        end
        if (eligible_i[IDW'(j)]) begin
          valid_o = 1'b1;
          idx_o   = IDW'(j);
        end
      end
    end else begin
      // Ascending scan, last hit kept: the highest eligible index wins.
      for (int k = 0; k < NUM_WRITERS; k++) begin
        if (eligible_i[IDW'(k)]) begin
          valid_o = 1'b1;
          idx_o   = IDW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/arbiter_rr.sv
// rtl/arbiter_rr.sv - multi-writer to single-FIFO write arbiter, one-cycle grants
//
// Purpose: each cycle registers at most one winner among requesting writers,
// strobing its word into the FIFO the following cycle.
// Ports:
//   i_clk      clock, all state on rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        arbiter_rr_if slave: i_req/i_data/i_fifo_full in,
//              o_busy/o_we/o_data/o_grant_id out
// Parameters: NUM_WRITERS (>= 2), DATA_WIDTH, ROUND_ROBIN (1 rotating, 0 fixed highest-wins).
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int NUM_WRITERS = NUM_WRITERS_DEF,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter bit ROUND_ROBIN = ROUND_ROBIN_DEF
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  arbiter_rr_if.slave  bus
);

  localparam int IDW = id_width(NUM_WRITERS);

  logic [NUM_WRITERS-1:0] busy_q, busy_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [IDW-1:0]         gid_q, gid_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic                   armed_q;

  logic [NUM_WRITERS-1:0] eligible;
  logic                   pick_valid;
  logic [IDW-1:0]         pick_idx;

  // busy_q is all ones except for the writer being granted right now, so
  // ANDing it in removes that writer (its request is still high while it
  // sees the grant). armed_q holds off grants on the first edge after reset.
  assign eligible = bus.i_req & busy_q
                  & {NUM_WRITERS{armed_q & ~bus.i_fifo_full}};

  arbiter_rr_pick #(
    .NUM_WRITERS (NUM_WRITERS)
  ) u_pick (
    .eligible_i    (eligible),
    .ptr_i         (ptr_q),
    .round_robin_i (ROUND_ROBIN),
    .valid_o       (pick_valid),
    .idx_o         (pick_idx)
  );

  always_comb begin
    busy_d = '1;
    we_d   = 1'b0;
    data_d = data_q;
    gid_d  = gid_q;
    ptr_d  = ptr_q;
    if (pick_valid) begin
      busy_d[pick_idx] = 1'b0;
      we_d             = 1'b1;
      gid_d            = pick_idx;
      // Data mux keyed by the winner index that is being registered.
      data_d = '0;
      for (int k = 0; k < NUM_WRITERS; k++) begin
        if (pick_idx == IDW'(k)) begin
          data_d = bus.i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (ROUND_ROBIN) begin
        ptr_d = (pick_idx == IDW'(NUM_WRITERS - 1)) ? '0 : pick_idx + IDW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      busy_q  <= '1;
      we_q    <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      we_q    <= we_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      armed_q <= 1'b1;
    end
  end

  assign bus.o_busy     = busy_q;
  assign bus.o_we       = we_q;
  assign bus.o_data     = data_q;
  assign bus.o_grant_id = gid_q;

endmodule
